// File: rtl/d_cache_pkg.sv
// Shared types and defaults for the data-cache arbiter slice.
// Also provides a small helper to size requester index fields.
package d_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/d_cache_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request
// found at or after the pointer, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
                o_valid = 1'b1;
                o_grant[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
                o_idx   = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/d_cache_arbiter.sv
// Round-robin arbiter sharing the single-port data cache between requesters,
// with a watchdog that aborts accesses whose cache valid never arrives.
module d_cache_arbiter
    import d_cache_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_write_valid_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_valid_i,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [WDOG_W-1:0]    r_wdog;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic [DATA_W-1:0]    r_rdata;

    logic [NUM_REQ-1:0]   w_pick_grant;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0]   w_owner_onehot;
    logic                 w_accept;
    logic                 w_finish;
    logic                 w_abort;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Abort only when TIMEOUT empty cycles have already elapsed and the
    // current one is empty too; a late valid always wins over the watchdog.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_valid_i) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end else if ((TIMEOUT > 0) && (r_wdog == WDOG_W'(TIMEOUT))) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_ptr_next     = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);
        w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wdog  <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_we    <= we_i[w_pick_idx];
                r_addr  <= addr_i[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                r_wdata <= wdata_i[int'(w_pick_idx)*DATA_W +: DATA_W];
                r_owner <= w_pick_idx;
                r_ptr   <= w_ptr_next;
                r_gnt   <= w_pick_grant;
                r_wdog  <= '0;
            end
            if ((r_state == BUSY) && !mem_valid_i && !w_abort) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_finish || w_abort) begin
                r_done  <= w_owner_onehot;
                r_err   <= w_abort;
                r_rdata <= (w_finish && !r_we) ? mem_rdata_i : '0;
            end
        end
    end

    assign gnt_o             = r_gnt;
    assign done_o            = r_done;
    assign err_o             = r_err;
    assign rdata_o           = r_rdata;
    assign mem_addr_o        = r_addr;
    assign mem_wdata_o       = r_wdata;
    assign mem_write_valid_o = (r_state == BUSY) && r_we;

endmodule

// File: tb/tb_d_cache_arbiter.sv
// Self-checking bench for d_cache_arbiter: directed vector table, hand-written
// corner sequences, and randomized transactions against a behavioural model.
module tb_d_cache_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, done;
    logic        err;
    logic [31:0] rdata;
    logic        memWv;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memValid;

    logic [31:0] mem    [0:255];
    logic [31:0] refMem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign memRdata = mem[memAddr[7:0]];

    d_cache_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (req),
        .we_i              (we),
        .addr_i            ({addr1, addr0}),
        .wdata_i           ({wdata1, wdata0}),
        .gnt_o             (gnt),
        .done_o            (done),
        .err_o             (err),
        .rdata_o           (rdata),
        .mem_write_valid_o (memWv),
        .mem_addr_o        (memAddr),
        .mem_wdata_o       (memWdata),
        .mem_valid_i       (memValid),
        .mem_rdata_i       (memRdata)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        int          stalls;
        logic [1:0]  expGnt;
        logic        expErr;
        logic [31:0] expRdata;
        int          expDone;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReset;
        rst = 1'b1; req = '0; we = '0; memValid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // One full transaction: present request, expect grant, stall memValid, expect done.
    task automatic applyStimulus(input string tag, input logic [1:0] r, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1, input int stalls,
                                 input logic [1:0] expGnt, input logic expErr,
                                 input logic [31:0] expRdata, input int expDone);
        int          doneCyc;
        logic        commit;
        logic [7:0]  cA;
        logic [31:0] cD;
        logic        expWe;
        logic [31:0] expAddr;
        expWe   = expGnt[1] ? w[1] : w[0];
        expAddr = expGnt[1] ? a1 : a0;
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        memValid = 1'b0;
        doneCyc = -1;
        tick;
        checkOutput({tag, " gnt"}, 32'(gnt), 32'(expGnt));
        req = '0;
        for (int c = 1; c <= 20; c++) begin
            checkOutput({tag, " wvalid"}, 32'(memWv), 32'(expWe));
            checkOutput({tag, " addr"}, memAddr, expAddr);
            memValid = (c > stalls);
            commit = memWv && memValid;
            cA = memAddr[7:0];
            cD = memWdata;
            tick;
            if (commit) mem[cA] = cD;
            if (done != 2'b00) begin
                doneCyc = c + 1;
                break;
            end
        end
        checkOutput({tag, " doneCycle"}, 32'(doneCyc), 32'(expDone));
        checkOutput({tag, " done"}, 32'(done), 32'(expGnt));
        checkOutput({tag, " err"}, 32'(err), 32'(expErr));
        checkOutput({tag, " rdata"}, rdata, expRdata);
        checkOutput({tag, " idleWvalid"}, 32'(memWv), 32'd0);
        memValid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [1:0] expG [8];
        logic [1:0] expD [8];
        int         ptr;
        int         win;
        logic [1:0] r, w;
        logic [31:0] a [2];
        logic [31:0] d [2];
        int         stalls;
        bit         abort;
        logic [31:0] expRd;

        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;

        doReset;
        rst = 1'b1;
        tick;
        checkOutput("reset gnt", 32'(gnt), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset wvalid", 32'(memWv), 32'd0);
        checkOutput("reset addr", memAddr, 32'd0);
        checkOutput("reset wdata", memWdata, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        rst = 1'b0;

        vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,         32'h0,         0, 2'b01, 1'b0, 32'hDEADBEEF, 2};
        vecs[1] = '{2'b01, 2'b01, 32'h20, 32'h0,  32'h12345678,  32'h0,         0, 2'b01, 1'b0, 32'h0,        2};
        vecs[2] = '{2'b10, 2'b00, 32'h0,  32'h20, 32'h0,         32'h0,         0, 2'b10, 1'b0, 32'h12345678, 2};
        vecs[3] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0,         32'h0,         3, 2'b01, 1'b0, 32'hDEADBEEF, 5};
        vecs[4] = '{2'b11, 2'b10, 32'h10, 32'h30, 32'h0,         32'hA5A5A5A5,  3, 2'b10, 1'b0, 32'h0,        5};
        vecs[5] = '{2'b10, 2'b00, 32'h0,  32'h30, 32'h0,         32'h0,         6, 2'b10, 1'b1, 32'h0,        6};
        vecs[6] = '{2'b01, 2'b00, 32'h30, 32'h0,  32'h0,         32'h0,         0, 2'b01, 1'b0, 32'hA5A5A5A5, 2};
        vecs[7] = '{2'b10, 2'b00, 32'h0,  32'h10, 32'h0,         32'h0,         4, 2'b10, 1'b0, 32'hDEADBEEF, 6};

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1,
                          vecs[i].d0, vecs[i].d1, vecs[i].stalls, vecs[i].expGnt, vecs[i].expErr,
                          vecs[i].expRdata, vecs[i].expDone);
        end

        // Both requesters held with zero stall: grants alternate every 2 cycles.
        doReset;
        expG = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        expD = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        memValid = 1'b1; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20; req = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick;
            checkOutput($sformatf("rr gnt c%0d", c + 1), 32'(gnt), 32'(expG[c]));
            checkOutput($sformatf("rr done c%0d", c + 1), 32'(done), 32'(expD[c]));
        end
        req = 2'b00;
        tick;
        tick;
        memValid = 1'b0;

        // Reset during a stalled write: no done, strobe drops, pointer back to 0.
        doReset;
        req = 2'b01; we = 2'b01; addr0 = 32'h40; wdata0 = 32'h77;
        tick;
        checkOutput("rstBusy gnt", 32'(gnt), 32'b01);
        req = 2'b00;
        tick;
        checkOutput("rstBusy wvalid", 32'(memWv), 32'd1);
        rst = 1'b1;
        tick;
        checkOutput("rstBusy wvalidAfter", 32'(memWv), 32'd0);
        checkOutput("rstBusy noDone", 32'(done), 32'd0);
        rst = 1'b0;
        req = 2'b11; we = 2'b00;
        tick;
        checkOutput("rstBusy ptrReset", 32'(gnt), 32'b01);
        req = 2'b00; memValid = 1'b1;
        tick;
        checkOutput("rstBusy doneAfter", 32'(done), 32'b01);
        memValid = 1'b0;

        // Randomized transactions against the behavioural model.
        doReset;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        ptr = 0;
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            w = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                a[k] = $urandom;
                d[k] = $urandom;
            end
            stalls = $urandom_range(0, 6);
            win = r[ptr] ? ptr : (ptr + 1) % 2;
            ptr = (win + 1) % 2;
            abort = (stalls > TIMEOUT);
            expRd = (abort || w[win]) ? 32'h0 : refMem[a[win][7:0]];
            if (!abort && w[win]) refMem[a[win][7:0]] = d[win];
            applyStimulus($sformatf("rnd%0d", n), r, w, a[0], a[1], d[0], d[1], stalls,
                          (win == 1) ? 2'b10 : 2'b01, abort, expRd,
                          abort ? TIMEOUT + 2 : stalls + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
